// File: rtl/pa_perips_uart_txsched.sv
// pa_perips_uart_txsched
//   Round-robin transmit scheduler that lets two byte-stream requesters share
//   one UART register port. It is the only master on that port: after reset
//   it enables the UART once by writing CR. For each granted byte it writes
//   TXD, polls SR until the tx-done flag is set, then clears the flag. A
//   byte whose done flag never arrives is abandoned after TIMEOUT_CYCLES
//   polls, and the sticky err_o is raised.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   req_valid_i[1:0]    per-requester byte valid (bit n = requester n)
//   req_data_i[15:0]    [7:0] requester 0, [15:8] requester 1
//   req_ready_o[1:0]    one-hot accept; handshake = valid & ready
//   done_o[1:0]         one-cycle pulse to the requester whose byte finished
//   err_o / err_clr_i   sticky timeout flag and its clear
//   busy_o              high whenever the scheduler is not idle
//   uart_*              UART register port (addr, rd/we strobes, wdata, rdata)

module pa_perips_uart_txsched #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
    parameter logic [31:0] CR_INIT        = 32'h0000_0003
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    output logic [1:0]  req_ready_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    input  logic        err_clr_i,
    output logic        busy_o,
    output logic [7:0]  uart_addr_o,
    output logic        uart_rd_o,
    output logic        uart_we_o,
    output logic [31:0] uart_wdata_o,
    input  logic [31:0] uart_rdata_i
);

    localparam logic [7:0] ADDR_CR  = 8'h00;
    localparam logic [7:0] ADDR_SR  = 8'h04;
    localparam logic [7:0] ADDR_TXD = 8'h10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_POLL,
        ST_CHECK,
        ST_CLR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // Round-robin choice: prefer the requester that was not served last.
    logic any_valid;
    logic other_req;
    logic gnt_sel;
    logic tx_done;
    logic timed_out;

    // Only SR bit0 matters; the upper read bits are deliberately ignored.
    logic unused_rdata;
    assign unused_rdata = ^uart_rdata_i[31:1];

    assign any_valid = |req_valid_i;
    assign other_req = ~last_grant_q;
    assign gnt_sel   = req_valid_i[other_req] ? other_req : last_grant_q;
    assign tx_done   = uart_rdata_i[0];
    assign timed_out = (cnt_q >= TIMEOUT_CYCLES);

    // State register and latched datapath.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_INIT;
            byte_q       <= 8'h00;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-datapath logic.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        // Clear first so a same-cycle timeout below overrides it.
        if (err_clr_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_valid) begin
                    byte_d       = gnt_sel ? req_data_i[15:8] : req_data_i[7:0];
                    gnt_d        = gnt_sel;
                    last_grant_d = gnt_sel;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = 32'd0;
                state_d = ST_POLL;
            end
            ST_POLL: begin
                // Saturating poll counter: a hung UART must never wrap it.
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (tx_done) begin
                    state_d = ST_CLR;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Output decode. Bus strobes are held low while reset is asserted even
    // though the state register already sits in INIT, so the port is quiet
    // until reset is released.
    always_comb begin
        req_ready_o  = 2'b00;
        done_o       = 2'b00;
        uart_addr_o  = 8'h00;
        uart_rd_o    = 1'b0;
        uart_we_o    = 1'b0;
        uart_wdata_o = 32'h0;
        if (rst_n_i) begin
            case (state_q)
                ST_INIT: begin
                    uart_we_o    = 1'b1;
                    uart_addr_o  = ADDR_CR;
                    uart_wdata_o = CR_INIT;
                end
                ST_IDLE: begin
                    if (any_valid) begin
                        req_ready_o = gnt_sel ? 2'b10 : 2'b01;
                    end
                end
                ST_SEND: begin
                    uart_we_o    = 1'b1;
                    uart_addr_o  = ADDR_TXD;
                    uart_wdata_o = {24'h0, byte_q};
                end
                ST_POLL: begin
                    uart_rd_o   = 1'b1;
                    uart_addr_o = ADDR_SR;
                end
                ST_CLR: begin
                    uart_we_o    = 1'b1;
                    uart_addr_o  = ADDR_SR;
                    uart_wdata_o = 32'h1;
                    done_o       = gnt_q ? 2'b10 : 2'b01;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_pa_perips_uart_txsched.sv
`timescale 1ns/1ps
module tb_pa_perips_uart_txsched;

    localparam int         TO    = 10;
    localparam logic [7:0] A_CR  = 8'h00;
    localparam logic [7:0] A_SR  = 8'h04;
    localparam logic [7:0] A_TXD = 8'h10;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         k;         // poll on which SR bit0 reads as 1
        bit         timeout;   // SR never reports done
        bit         clr_hold;  // err_clr_i held high for the whole transfer
        int         hs_cyc;
    } item_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  req_valid_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  done_o;
    logic        err_o;
    logic        err_clr_i;
    logic        busy_o;
    logic [7:0]  uart_addr_o;
    logic        uart_rd_o;
    logic        uart_we_o;
    logic [31:0] uart_wdata_o;
    logic [31:0] uart_rdata_i;

    pa_perips_uart_txsched #(
        .TIMEOUT_CYCLES(32'd10),
        .CR_INIT       (32'h0000_0003)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i),
        .busy_o       (busy_o),
        .uart_addr_o  (uart_addr_o),
        .uart_rd_o    (uart_rd_o),
        .uart_we_o    (uart_we_o),
        .uart_wdata_o (uart_wdata_o),
        .uart_rdata_i (uart_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    int    cyc      = 0;
    item_t exp_q[$];
    int    gnt_log[$];
    bit    model_last = 1'b1;
    bit    err_exp    = 1'b0;
    bit [1:0] acc_seen = 2'b00;
    int    hs_cnt   = 0;
    int    done_cnt = 0;
    int    force_k  = 0;
    bit    force_to = 1'b0;
    bit    rand_to  = 1'b0;
    int    polls    = 0;
    int    cur_k    = 1;
    bit    cur_to   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference grant rule: the requester not served last wins a tie.
    function automatic int pick(input logic [1:0] v, input bit last);
        if (v == 2'b00) return -1;
        if (v == 2'b11) return last ? 0 : 1;
        return v[1] ? 1 : 0;
    endfunction

    // Model: predicts the grant in IDLE and pushes the expected transfer.
    always @(negedge clk_i) begin : model
        int    g;
        item_t it;
        if (rst_n_i) begin
            acc_seen = acc_seen | (req_ready_o & req_valid_i);
            if ((req_ready_o & req_valid_i) != 2'b00) gnt_log.push_back(req_ready_o[1] ? 1 : 0);
            if (!busy_o) begin
                g = pick(req_valid_i, model_last);
                check("ready_grant", {30'h0, req_ready_o}, (g < 0) ? 32'h0 : (32'h1 << g));
                if (g >= 0) begin
                    it.port     = g;
                    it.data     = req_data_i[8*g +: 8];
                    it.timeout  = force_to || (rand_to && $urandom_range(0, 5) == 0);
                    it.k        = (force_k != 0) ? force_k : int'($urandom_range(1, 4));
                    it.clr_hold = err_clr_i;
                    it.hs_cyc   = cyc;
                    exp_q.push_back(it);
                    model_last = g[0];
                    hs_cnt++;
                end
            end
        end
    end

    // UART register model: SR bit0 reads as 1 from the k-th poll on.
    always @(negedge clk_i) begin : uart_model
        logic [31:0] r;
        if (rst_n_i) begin
            if (uart_we_o && uart_addr_o == A_TXD && exp_q.size() > 0) begin
                polls  = 0;
                cur_k  = exp_q[0].k;
                cur_to = exp_q[0].timeout;
            end
            if (uart_rd_o) begin
                polls++;
                r    = $urandom();
                r[0] = !cur_to && (polls >= cur_k);
                uart_rdata_i = r;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk_i) begin : monitor
        item_t it;
        int    keff;
        if (rst_n_i) begin
            if (uart_rd_o) check("poll_addr", {24'h0, uart_addr_o}, {24'h0, A_SR});
            if (uart_we_o && uart_addr_o == A_TXD) begin
                if (exp_q.size() == 0) check("txd_unexpected", 32'h1, 32'h0);
                else check("txd_data", uart_wdata_o, {24'h0, exp_q[0].data});
            end
            if (done_o != 2'b00) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {30'h0, done_o}, 32'h0);
                end else begin
                    it   = exp_q.pop_front();
                    keff = it.timeout ? TO : it.k;
                    if (it.timeout) err_exp = 1'b1;
                    check("done_port", {30'h0, done_o}, 32'h1 << it.port);
                    check("done_latency", cyc - it.hs_cyc, 2 + 2 * keff);
                    check("clr_write", {31'h0, uart_we_o && uart_addr_o == A_SR && uart_wdata_o == 32'h1}, 32'h1);
                    check("err_at_done", {31'h0, err_o}, {31'h0, err_exp});
                    if (it.clr_hold) err_exp = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'h0, busy_o},      32'h1);
        check({tag, "_we"},    {31'h0, uart_we_o},   32'h0);
        check({tag, "_rd"},    {31'h0, uart_rd_o},   32'h0);
        check({tag, "_addr"},  {24'h0, uart_addr_o}, 32'h0);
        check({tag, "_wdata"}, uart_wdata_o,         32'h0);
        check({tag, "_done"},  {30'h0, done_o},      32'h0);
        check({tag, "_ready"}, {30'h0, req_ready_o}, 32'h0);
        check({tag, "_err"},   {31'h0, err_o},       32'h0);
    endtask

    task automatic check_init(input string tag);
        @(negedge clk_i);
        check({tag, "_we"},    {31'h0, uart_we_o},   32'h1);
        check({tag, "_addr"},  {24'h0, uart_addr_o}, {24'h0, A_CR});
        check({tag, "_wdata"}, uart_wdata_o,         32'h3);
        check({tag, "_busy"},  {31'h0, busy_o},      32'h1);
        @(negedge clk_i);
        check({tag, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_idle_strb"}, {30'h0, uart_we_o, uart_rd_o}, 32'h0);
    endtask

    task automatic wait_hs(input int n);
        int start = hs_cnt;
        int t = 0;
        while (hs_cnt < start + n && t < 500) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (hs_cnt < start + n) check("hs_wait", hs_cnt - start, n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) check("idle_wait", {31'h0, busy_o}, 32'h0);
        @(posedge clk_i); #1;
    endtask

    task automatic send_one(input int port, input logic [7:0] data);
        acc_seen = 2'b00;
        @(posedge clk_i); #1;
        req_data_i[8*port +: 8] = data;
        req_valid_i[port] = 1'b1;
        wait_hs(1);
        req_valid_i = 2'b00;
        req_data_i  = 16'hFFFF;   // later changes must not reach TXD
        wait_idle();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        int t;
        rst_n_i = 1'b1; req_valid_i = 2'b00; req_data_i = 16'h0;
        err_clr_i = 1'b0; uart_rdata_i = 32'h0;
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        check_init("init");

        // Both requesters valid continuously: strict alternation from port 0.
        @(posedge clk_i); #1;
        gnt_log.delete(); acc_seen = 2'b00;
        req_data_i = 16'hB2A1; req_valid_i = 2'b11;
        wait_hs(4);
        req_valid_i = 2'b00;
        wait_idle();
        check("gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("gnt_seq", gnt_log[i], i % 2);

        // Directed byte: done on the 3rd poll, 9 cycles including handshake.
        force_k = 3;
        send_one(0, 8'h55);
        force_k = 0;

        // Single active port is served back-to-back.
        acc_seen = 2'b00;
        req_data_i = 16'h6600; req_valid_i = 2'b10;
        wait_hs(3);
        req_valid_i = 2'b00;
        wait_idle();

        // Timeout, then a separate err_clr pulse.
        force_to = 1'b1;
        send_one(1, 8'h3C);
        force_to = 1'b0;
        check("err_sticky", {31'h0, err_o}, 32'h1);
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0; err_exp = 1'b0;
        check("err_cleared", {31'h0, err_o}, 32'h0);

        // err_clr held through a timeout: the set wins in that cycle.
        err_clr_i = 1'b1; force_to = 1'b1;
        send_one(0, 8'hC3);
        err_clr_i = 1'b0; force_to = 1'b0;
        check("err_after_hold", {31'h0, err_o}, 32'h0);

        // Randomized traffic with occasional timeouts.
        rand_to = 1'b1; acc_seen = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_i); #1;
            for (int n = 0; n < 2; n++) begin
                if (req_valid_i[n] && acc_seen[n]) begin
                    acc_seen[n] = 1'b0;
                    req_valid_i[n] = 1'($urandom_range(0, 1));
                    req_data_i[8*n +: 8] = 8'($urandom());
                end else if (req_valid_i[n]) begin
                    if ($urandom_range(0, 15) == 0) req_valid_i[n] = 1'b0;
                    else if ($urandom_range(0, 7) == 0) req_data_i[8*n +: 8] = 8'($urandom());
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid_i[n] = 1'b1;
                    req_data_i[8*n +: 8] = 8'($urandom());
                end
            end
        end
        req_valid_i = 2'b00;
        wait_idle();
        rand_to = 1'b0;

        // Reset mid-poll: in-flight byte dropped, CR rewritten, port 0 first.
        force_k = 4;
        acc_seen = 2'b00;
        req_data_i = 16'h7700; req_valid_i = 2'b10;
        wait_hs(1);
        req_valid_i = 2'b00;
        t = 0;
        while (!uart_rd_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("poll_seen", {31'h0, uart_rd_o}, 32'h1);
        #1 rst_n_i = 1'b0;
        exp_q.delete(); model_last = 1'b1; err_exp = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        force_k = 0;
        check_init("reinit");
        @(posedge clk_i); #1;
        gnt_log.delete(); acc_seen = 2'b00;
        req_data_i = 16'h2211; req_valid_i = 2'b11;
        wait_hs(2);
        req_valid_i = 2'b00;
        wait_idle();
        check("post_rst_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
